stall_data_mem: RTL and testbench
=================================

// Module: stall_data_mem
// PURPOSE
//  Multi-cycle data memory for the memory stage of the 5-stage pipeline. It takes one
//  word read or write at a time from EX/MEM and holds the pipeline with Stall until the
//  access completes after a fixed LATENCY. It signals completion with a one-cycle Done
//  pulse. It flags misaligned and conflicting requests on err, which feeds the processor
//  error OR.
// PARAMETERS
//  LATENCY    4    cycles from accept to Done; legal range 1..15
//  MEM_WORDS  256  16-bit words of storage; power of 2, <= 32768
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  rst        in   1   synchronous reset, active high
//  Addr       in   16  byte address; bit 0 must be 0
//  DataIn     in   16  write data
//  Rd         in   1   read request
//  Wr         in   1   write request
//  DataOut    out  16  read data, valid while Done=1; held until the next read completes
//  Done       out  1   one-cycle completion pulse
//  Stall      out  1   pipeline hold request; combinational
//  err        out  1   illegal request; combinational, asserted only in IDLE
// BEHAVIOUR
//  - Reset (rst=1 at an edge):
//    - state=IDLE, cnt=0, DataOut=0, Done=0.
//    - Array contents are not changed.
//    - Reset during BUSY aborts the access; an uncommitted write is dropped.
//  - Word index = Addr[log2(MEM_WORDS):1]. Upper address bits are ignored, so the
//    address space wraps.
//  - State IDLE:
//    - Valid request = (Rd^Wr) & ~Addr[0].
//    - err = (Rd&Wr) | ((Rd|Wr)&Addr[0]). No access is made and Stall=0 on error.
//    - In accept cycle T: latch op, word index and DataIn. Set cnt=LATENCY-1.
//      Go to BUSY if LATENCY>1, else go to DONE (committing the access at the T edge).
//    - Stall=1 combinationally in cycle T.
//  - State BUSY:
//    - Stall=1 and err=0. Inputs are ignored; the latched values are used.
//    - cnt decrements each cycle.
//    - At the edge where cnt==1, commit the access and go to DONE:
//      - write: mem[idx] <= latched data
//      - read:  DataOut <= mem[idx]
//  - State DONE:
//    - Done=1, Stall=0, err=0.
//    - Always go to IDLE next cycle. The still-asserted request is not re-accepted.
//  - Timing:
//    - Stall is high for exactly LATENCY cycles (T..T+LATENCY-1).
//    - Done is high in cycle T+LATENCY. The next accept is at T+LATENCY+1 at the earliest.
//  - Writes never change DataOut.
//  - Read of a word written by the immediately preceding access returns the new data.
// TESTING  (LATENCY=4, MEM_WORDS=256)
//  1. Reset, then Wr=1 Addr=0x0010 DataIn=0xBEEF held:
//     -> Stall=1 for 4 cycles, Done=1 in the 5th, err=0.
//     Then Rd=1 Addr=0x0010 -> Done cycle shows DataOut=0xBEEF.
//  2. Rd=1 Addr=0x0011 -> err=1, Stall=0, Done never asserts; DataOut unchanged.
//     Rd=1 Wr=1 Addr=0x0020 -> err=1, no access.
//  3. Wr 0x1234 to Addr=0x0002, then Rd Addr=0x0202:
//     -> DataOut=0x1234 (index wrap).
//  4. Accept Wr 0x5555 to 0x0040 (old value 0xAAAA), assert rst in cycle T+2:
//     -> next cycle state=IDLE, Done=0, DataOut=0, Stall=0.
//     A later read of 0x0040 returns 0xAAAA.
//  5. Rd held high across Done:
//     -> exactly one access, Stall low in the Done cycle.
//     Re-accept in the following cycle, giving a Done period of 5 cycles.
//  6. LATENCY=1 build: Wr then Rd at same address back to back:
//     -> each access has Stall for 1 cycle and Done in the next, and the read returns the
//     written data.

Source files
------------

// File: rtl/stall_data_mem.sv
// Multi-cycle word data memory for the MEM stage. It accepts one aligned read or write,
// holds the pipeline with Stall for LATENCY cycles, then pulses Done for one cycle.
//
// state | meaning
// IDLE  | waiting for a request; flags illegal requests on err
// BUSY  | access in flight; cnt counts down to the commit edge
// DONE  | access committed; Done pulse; never re-accepts in this cycle
module stall_data_mem #(
    parameter int LATENCY   = 4,
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        err
);
    localparam int IDX_W = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, stateNext;
    logic [3:0]         cnt, cntNext;
    logic               opWr;
    logic [IDX_W-1:0]   idxQ;
    logic [15:0]        dataQ;
    logic [15:0]        mem [MEM_WORDS];

    logic [IDX_W-1:0]   reqIdx;
    logic               reqValid;
    logic               accept;
    logic               commit;
    logic               commitWr;
    logic [IDX_W-1:0]   commitIdx;
    logic [15:0]        commitData;

    // Upper address bits are deliberately ignored so the address space wraps.
    assign reqIdx = Addr[IDX_W:1];
    generate
        if (IDX_W < 15) begin : gUnusedAddr
            logic unusedAddrBits;
            assign unusedAddrBits = &Addr[15:IDX_W+1];
        end
    endgenerate

    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        Stall      = 1'b0;
        err        = 1'b0;
        Done       = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        commitWr   = opWr;
        commitIdx  = idxQ;
        commitData = dataQ;
        reqValid   = (Rd ^ Wr) & ~Addr[0];
        case (state)
            IDLE: begin
                err = (Rd & Wr) | ((Rd | Wr) & Addr[0]);
                if (reqValid) begin
                    accept  = 1'b1;
                    Stall   = 1'b1;
                    cntNext = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        // Single-cycle build commits straight from the request inputs.
                        commit     = 1'b1;
                        commitWr   = Wr;
                        commitIdx  = reqIdx;
                        commitData = DataIn;
                        stateNext  = DONE;
                    end else begin
                        stateNext = BUSY;
                    end
                end
            end
            BUSY: begin
                Stall   = 1'b1;
                cntNext = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    commit    = 1'b1;
                    stateNext = DONE;
                end
            end
            DONE: begin
                Done      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            DataOut <= 16'h0000;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (commit && !commitWr) begin
                DataOut <= mem[commitIdx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            opWr  <= Wr;
            idxQ  <= reqIdx;
            dataQ <= DataIn;
        end
    end

    // Array is never reset; gating on rst drops a write aborted by reset.
    always_ff @(posedge clk) begin
        if (!rst && commit && commitWr) begin
            mem[commitIdx] <= commitData;
        end
    end
endmodule

// File: tb/tb_stall_data_mem.sv
// Bench for stall_data_mem: randomized and directed accesses against an array model,
// with a Done-driven scoreboard monitor and a small LATENCY=1 instance.
module tb_stall_data_mem;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Addr, DataIn, DataOut;
    logic        Rd, Wr, Done, Stall, err;
    logic [15:0] Addr1, DataIn1, DataOut1;
    logic        Rd1, Wr1, Done1, Stall1, err1;

    stall_data_mem #(.LATENCY(LAT), .MEM_WORDS(256)) dut (
        .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .DataOut(DataOut), .Done(Done), .Stall(Stall), .err(err)
    );

    stall_data_mem #(.LATENCY(1), .MEM_WORDS(256)) dut1 (
        .clk(clk), .rst(rst), .Addr(Addr1), .DataIn(DataIn1), .Rd(Rd1), .Wr(Wr1),
        .DataOut(DataOut1), .Done(Done1), .Stall(Stall1), .err(err1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nTests = 0;
    int nFail  = 0;

    logic [15:0] model [256];
    logic [15:0] lastRead;

    typedef struct {
        int          doneCyc;
        logic [15:0] dataOut;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int wordIdx(input logic [15:0] a);
        return (int'(a) / 2) % 256;
    endfunction

    // Scoreboard monitor: every Done pulse must match the oldest outstanding access.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && Done) begin
            check("sb_nonempty_at_done", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("done_cycle", cyc, e.doneCyc);
                check("dataout_at_done", DataOut, e.dataOut);
            end
        end
    end

    task automatic access(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        logic isErr, valid;
        exp_t e;
        @(posedge clk); #1;
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        isErr = (rd & wr) | ((rd | wr) & a[0]);
        valid = (rd ^ wr) & ~a[0];
        @(negedge clk);
        check("err_accept", err, isErr);
        check("stall_accept", Stall, valid);
        if (!valid) begin
            check("done_on_err", Done, 0);
            return;
        end
        e.doneCyc = cyc + LAT;
        e.dataOut = rd ? model[wordIdx(a)] : lastRead;
        sb.push_back(e);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            check("stall_busy", Stall, k < LAT);
            check("done_busy", Done, k == LAT);
            check("err_busy", err, 0);
        end
        if (wr) model[wordIdx(a)] = d;
        else    lastRead = model[wordIdx(a)];
    endtask

    task automatic idle();
        @(posedge clk); #1;
        Rd = 1'b0; Wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  pool [8];
        logic [15:0] a;
        int          kind;
        logic        rdBit;

        rst = 1'b1; Rd = 0; Wr = 0; Addr = 0; DataIn = 0;
        Rd1 = 0; Wr1 = 0; Addr1 = 0; DataIn1 = 0;
        lastRead = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_done", Done, 0);
        check("reset_stall", Stall, 0);
        check("reset_dataout", DataOut, 16'h0000);
        check("reset_err", err, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Write then read back, inputs held through the first access
        access(0, 1, 16'h0010, 16'hBEEF);
        access(1, 0, 16'h0010, 16'h0000);
        idle();

        // Illegal requests: misaligned and simultaneous read/write
        access(1, 0, 16'h0011, 16'h0000);
        check("dataout_after_err", DataOut, lastRead);
        access(1, 1, 16'h0020, 16'h7777);
        idle();
        @(negedge clk);
        check("dataout_unchanged", DataOut, 16'hBEEF);

        // Index wrap
        access(0, 1, 16'h0002, 16'h1234);
        idle();
        access(1, 0, 16'h0202, 16'h0000);
        idle();

        // Reset in the middle of a write drops it
        access(0, 1, 16'h0040, 16'hAAAA);
        idle();
        @(posedge clk); #1;
        Wr = 1'b1; Addr = 16'h0040; DataIn = 16'h5555;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; Wr = 1'b0;
        @(negedge clk);
        check("stall_before_abort", Stall, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        lastRead = 16'h0000;
        @(negedge clk);
        check("abort_done", Done, 0);
        check("abort_stall", Stall, 0);
        check("abort_dataout", DataOut, 16'h0000);
        access(1, 0, 16'h0040, 16'h0000);

        // Read held across Done: re-accept gives a five-cycle Done period
        access(1, 0, 16'h0010, 16'h0000);
        access(1, 0, 16'h0010, 16'h0000);
        idle();

        // Randomized traffic over a small pool of words
        for (int i = 0; i < 8; i++) begin
            pool[i] = 8'($urandom_range(0, 255));
            access(0, 1, {7'($urandom), pool[i], 1'b0}, 16'($urandom));
        end
        for (int i = 0; i < 40; i++) begin
            kind  = $urandom_range(0, 9);
            rdBit = 1'($urandom);
            a = {7'($urandom), pool[$urandom_range(0, 7)], 1'b0};
            if (kind == 0)      access(1, 1, a, 16'($urandom));
            else if (kind == 1) access(rdBit, ~rdBit, a | 16'h0001, 16'($urandom));
            else                access(rdBit, ~rdBit, a, 16'($urandom));
            if ($urandom_range(0, 2) == 0) idle();
        end
        idle();

        // LATENCY=1 instance: write then read back to back
        @(posedge clk); #1;
        Wr1 = 1'b1; Addr1 = 16'h0022; DataIn1 = 16'h3C3C;
        @(negedge clk);
        check("l1_wr_stall", Stall1, 1);
        check("l1_wr_done_early", Done1, 0);
        @(posedge clk); #1;
        Wr1 = 1'b0; Rd1 = 1'b1;
        @(negedge clk);
        check("l1_wr_done", Done1, 1);
        check("l1_done_stall", Stall1, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("l1_rd_stall", Stall1, 1);
        check("l1_rd_done_early", Done1, 0);
        @(posedge clk); #1;
        Rd1 = 1'b0;
        @(negedge clk);
        check("l1_rd_done", Done1, 1);
        check("l1_rd_data", DataOut1, 16'h3C3C);

        repeat (3) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
